if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RISC core.
- Owns the PC and drives the synchronous-read instruction memory, which is preloaded from the .dat image.
- Registers the fetched instruction into the IF/ID pipeline register consumed by decode.
- Handles hazard-unit stalls without losing the in-flight instruction, and branch/jump redirects from EX with squash.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).
- IMEM_AW, 10, instruction memory word-address width.
- NOP, 32'h0000_0000, encoding placed in if_id_ir when the slot is a bubble.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold IF/ID and PC this cycle.
- redirect  in  1  EX: taken branch/jump this cycle.
- redirect_pc  in  32  target for redirect; bits [1:0] ignored (forced 0).
- imem_en  out  1  read enable to instruction memory (combinational).
- imem_addr  out  IMEM_AW  word address = pc_f[IMEM_AW+1:2] (combinational).
- imem_rdata  in  32  read data, valid the cycle after imem_en=1.
- if_id_valid  out  1  IF/ID slot holds a real instruction.
- if_id_pc  out  32  PC of if_id_ir.
- if_id_ir  out  32  fetched instruction.

Interface decisions: one clock; reset is synchronous and active-high. The ports are clk and rst.

Behaviour:
- Internal state:
  - pc_f: next address to issue.
  - m_valid and pc_m: a read was issued last cycle for pc_m.
  - Hold buffer buf_ir / buf_pc.
  - FSM state RUN | HOLD.
- Reset (rst=1 at edge):
  - pc_f=RESET_PC, m_valid=0, state=RUN.
  - if_id_valid=0, if_id_pc=0, if_id_ir=NOP.
  - imem_en=0 while rst=1.
- Priority: rst > redirect > stall.
- imem_en = !rst && !redirect && !stall. Every cycle: m_valid<=imem_en, pc_m<=pc_f.
- RUN, stall=0, redirect=0:
  - if_id_valid<=m_valid, if_id_pc<=pc_m.
  - if_id_ir<=imem_rdata if m_valid, else NOP.
  - pc_f<=pc_f+4. Wraps mod 2^32, no flag.
- RUN, stall=1:
  - IF/ID and pc_f hold.
  - If m_valid, buf_ir<=imem_rdata, buf_pc<=pc_m, go HOLD. Otherwise stay RUN.
- HOLD, stall=1: everything holds, no issue.
- HOLD, stall=0:
  - if_id<= {1, buf_pc, buf_ir}, state<=RUN.
  - Issue pc_f (equal to buf_pc+4); pc_f<=pc_f+4.
  - Next cycle's rdata follows in order, with no bubble.
- Redirect (any state, regardless of stall):
  - pc_f<=redirect_pc & ~3, state<=RUN, m_valid<=0, buffer discarded.
  - if_id_valid<=0, if_id_ir<=NOP.
- Latency:
  - Address issue to if_id_valid=1 is 2 edges.
  - Redirect cycle to first target in IF/ID is 3 edges.
- Ordering guarantee: if_id_pc sequence is strictly fetch order. Never duplicate, never skip except on redirect.
- Reset mid-stall or mid-HOLD: buffer dropped, fetch restarts at RESET_PC.
- Memory is only ever read with imem_en=1. imem_rdata is ignored when m_valid=0.

Test Plan:
- Reset release, no stall, mem[i]=32'h1000_0000+i → if_id_valid first high 2 cycles after release with pc=0, ir=32'h1000_0000; then pc 4, 8, 12 on consecutive cycles, ir incrementing.
- Stall for 3 cycles while pc 8 is in IF/ID and pc 12 is in flight → IF/ID holds pc 8; imem_en=0 during the stall; after release IF/ID shows 12, then 16 on the next cycle; no gap, no repeat.
- Redirect to 32'h0000_0042 while streaming → next if_id_valid=0; pc_f=32'h40; IF/ID shows pc 32'h40 exactly 3 edges after the redirect cycle; the two younger fetches are squashed.
- Redirect coincident with stall in HOLD → redirect wins; buffer discarded; target fetched as above.
- rst asserted during HOLD → next cycle if_id_valid=0, ir=NOP; refetch starts at RESET_PC.
- pc_f near 32'hFFFF_FFFC via redirect → next pc issued is 0 (wrap); if_id_pc shows FFFF_FFFC then 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read instruction
// memory and fills the IF/ID register, with stall hold-buffering and redirect squash.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 10,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               if_id_valid,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_ir
);

    typedef enum logic {ST_RUN, ST_HOLD} state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [31:0] r_pc_f;
    logic [31:0] r_pc_m;
    logic        r_m_valid;
    logic [31:0] r_buf_ir;
    logic [31:0] r_buf_pc;
    logic        r_if_id_valid;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_ir;
    logic        w_imem_en;
    logic [31:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc & ~32'd3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // HOLD is entered only when a stall would otherwise drop the read in flight
    always_comb begin
        w_state_nx = r_state;
        if (redirect) begin
            w_state_nx = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:  if (stall && r_m_valid) w_state_nx = ST_HOLD;
                ST_HOLD: if (!stall)             w_state_nx = ST_RUN;
                default: w_state_nx = ST_RUN;
            endcase
        end
    end

    always_comb begin
        w_imem_en = !rst && !redirect && !stall;
        imem_en   = w_imem_en;
        imem_addr = r_pc_f[IMEM_AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f        <= RESET_PC;
            r_pc_m        <= '0;
            r_m_valid     <= 1'b0;
            r_buf_ir      <= NOP;
            r_buf_pc      <= '0;
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= '0;
            r_if_id_ir    <= NOP;
        end else begin
            r_m_valid <= w_imem_en;
            r_pc_m    <= r_pc_f;
            if (redirect) begin
                r_pc_f        <= w_redirect_pc;
                r_if_id_valid <= 1'b0;
                r_if_id_ir    <= NOP;
            end else if (r_state == ST_HOLD) begin
                if (!stall) begin
                    r_if_id_valid <= 1'b1;
                    r_if_id_pc    <= r_buf_pc;
                    r_if_id_ir    <= r_buf_ir;
                    r_pc_f        <= r_pc_f + 32'd4;
                end
            end else if (!stall) begin
                r_if_id_valid <= r_m_valid;
                r_if_id_pc    <= r_pc_m;
                r_if_id_ir    <= r_m_valid ? imem_rdata : NOP;
                r_pc_f        <= r_pc_f + 32'd4;
            end else if (r_m_valid) begin
                r_buf_ir <= imem_rdata;
                r_buf_pc <= r_pc_m;
            end
        end
    end

    assign if_id_valid = r_if_id_valid;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_ir    = r_if_id_ir;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a randomized
// stall/redirect run checked against a fetch-order stream model.
module tb_if_fetch_stage;

    localparam int unsigned AW  = 10;
    localparam logic [31:0] NOPV = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst, stall, redirect;
    logic [31:0]   redirect_pc;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          if_id_valid;
    logic [31:0]   if_id_pc, if_id_ir;

    logic [31:0] mem [0:(1<<AW)-1];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW), .NOP(NOPV)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_ir(if_id_ir)
    );

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [AW-1:0] a;
        a = pc[AW+1:2];
        return mem[a];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick; tick;
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", if_id_valid); end
        checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", if_id_pc); end
        checks++; if (if_id_ir !== NOPV) begin errors++; $display("FAIL reset_ir: got %h exp %h", if_id_ir, NOPV); end
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en: got %0b exp 0", imem_en); end
        rst = 1'b0;
        #1;
        checks++; if (imem_en !== 1'b1 || imem_addr !== '0) begin errors++; $display("FAIL release_issue: en=%0b addr=%h exp en=1 addr=0", imem_en, imem_addr); end
        tick;
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL latency_edge1: valid=%0b exp 0", if_id_valid); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4*k) || if_id_ir !== 32'h1000_0000 + 32'(k)) begin
                errors++; $display("FAIL stream_%0d: v=%0b pc=%h ir=%h exp v=1 pc=%h ir=%h", k, if_id_valid, if_id_pc, if_id_ir, 32'(4*k), 32'h1000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL stall_en_%0d: got %0b exp 0", k, imem_en); end
            tick;
            checks++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'd8 || if_id_ir !== 32'h1000_0002) begin
                errors++; $display("FAIL stall_hold_%0d: v=%0b pc=%h ir=%h exp v=1 pc=8 ir=10000002", k, if_id_valid, if_id_pc, if_id_ir);
            end
        end
        stall = 1'b0;
        #1;
        checks++; if (imem_en !== 1'b1 || imem_addr !== 10'd4) begin errors++; $display("FAIL unstall_issue: en=%0b addr=%h exp en=1 addr=4", imem_en, imem_addr); end
        for (int k = 3; k < 5; k++) begin
            tick;
            checks++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4*k) || if_id_ir !== 32'h1000_0000 + 32'(k)) begin
                errors++; $display("FAIL unstall_%0d: v=%0b pc=%h ir=%h exp pc=%h", k, if_id_valid, if_id_pc, if_id_ir, 32'(4*k));
            end
        end
    endtask

    task automatic test_redirect;
        redirect = 1'b1; redirect_pc = 32'h0000_0042;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL redir_en: got %0b exp 0", imem_en); end
        tick;
        redirect = 1'b0;
        checks++; if (if_id_valid !== 1'b0 || if_id_ir !== NOPV) begin errors++; $display("FAIL redir_squash: v=%0b ir=%h exp v=0 ir=NOP", if_id_valid, if_id_ir); end
        #1;
        checks++; if (imem_addr !== 10'h10) begin errors++; $display("FAIL redir_addr: got %h exp 010", imem_addr); end
        tick;
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_edge2: v=%0b exp 0", if_id_valid); end
        tick;
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || if_id_ir !== word_at(32'h40)) begin errors++; $display("FAIL redir_target: v=%0b pc=%h ir=%h exp pc=40", if_id_valid, if_id_pc, if_id_ir); end
        tick;
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h44) begin errors++; $display("FAIL redir_next: v=%0b pc=%h exp pc=44", if_id_valid, if_id_pc); end
    endtask

    task automatic test_redirect_in_hold;
        tick; tick;
        stall = 1'b1;
        tick; tick;
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL hold_redir_en: got %0b exp 0", imem_en); end
        tick;
        redirect = 1'b0; stall = 1'b0;
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL hold_redir_squash: v=%0b exp 0", if_id_valid); end
        #1;
        checks++; if (imem_addr !== 10'h40 || imem_en !== 1'b1) begin errors++; $display("FAIL hold_redir_addr: en=%0b addr=%h exp en=1 addr=040", imem_en, imem_addr); end
        tick;
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL hold_redir_gap: v=%0b exp 0", if_id_valid); end
        tick;
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_ir !== word_at(32'h100)) begin errors++; $display("FAIL hold_redir_target: v=%0b pc=%h ir=%h exp pc=100", if_id_valid, if_id_pc, if_id_ir); end
        tick;
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h104) begin errors++; $display("FAIL hold_redir_next: v=%0b pc=%h exp pc=104", if_id_valid, if_id_pc); end
    endtask

    task automatic test_reset_in_hold;
        stall = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        checks++; if (if_id_valid !== 1'b0 || if_id_ir !== NOPV || if_id_pc !== 32'h0) begin errors++; $display("FAIL hold_rst: v=%0b pc=%h ir=%h exp v=0 pc=0 ir=NOP", if_id_valid, if_id_pc, if_id_ir); end
        rst = 1'b0; stall = 1'b0;
        #1;
        checks++; if (imem_en !== 1'b1 || imem_addr !== '0) begin errors++; $display("FAIL hold_rst_issue: en=%0b addr=%h exp en=1 addr=0", imem_en, imem_addr); end
        tick; tick;
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_ir !== word_at(32'h0)) begin errors++; $display("FAIL hold_rst_refetch: v=%0b pc=%h ir=%h exp pc=0", if_id_valid, if_id_pc, if_id_ir); end
    endtask

    task automatic test_wrap;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick;
        redirect = 1'b0;
        #1;
        checks++; if (imem_addr !== 10'h3FF) begin errors++; $display("FAIL wrap_addr_hi: got %h exp 3ff", imem_addr); end
        tick;
        checks++; if (imem_addr !== 10'h000) begin errors++; $display("FAIL wrap_addr_lo: got %h exp 000", imem_addr); end
        tick;
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hFFFF_FFFC || if_id_ir !== word_at(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_top: v=%0b pc=%h ir=%h exp pc=fffffffc", if_id_valid, if_id_pc, if_id_ir); end
        tick;
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_ir !== word_at(32'h0)) begin errors++; $display("FAIL wrap_zero: v=%0b pc=%h ir=%h exp pc=0", if_id_valid, if_id_pc, if_id_ir); end
    endtask

    // Model: decode sees valid instructions in strict fetch order from the last redirect target
    task automatic test_random;
        logic [31:0] exp_pc, rp, pp, pi;
        logic        s, r, pv;
        int          seen;
        seen = 0;
        redirect = 1'b1; redirect_pc = 32'h0000_0200; stall = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        tick;
        exp_pc = 32'h200;
        for (int c = 0; c < 500; c++) begin
            s  = ($urandom_range(0, 9) < 3);
            r  = ($urandom_range(0, 99) < 6);
            rp = $urandom;
            stall = s; redirect = r; redirect_pc = rp;
            #1;
            checks++; if (imem_en !== (!s && !r)) begin errors++; $display("FAIL rnd_en_%0d: got %0b exp %0b", c, imem_en, (!s && !r)); end
            pv = if_id_valid; pp = if_id_pc; pi = if_id_ir;
            tick;
            if (r) begin
                checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rnd_squash_%0d: v=%0b exp 0", c, if_id_valid); end
                exp_pc = rp & ~32'd3;
            end else if (s) begin
                checks++; if (if_id_valid !== pv || if_id_pc !== pp || if_id_ir !== pi) begin errors++; $display("FAIL rnd_hold_%0d: v=%0b pc=%h ir=%h exp v=%0b pc=%h ir=%h", c, if_id_valid, if_id_pc, if_id_ir, pv, pp, pi); end
            end else if (if_id_valid === 1'b1) begin
                seen++;
                checks++; if (if_id_pc !== exp_pc || if_id_ir !== word_at(exp_pc)) begin errors++; $display("FAIL rnd_order_%0d: pc=%h ir=%h exp pc=%h ir=%h", c, if_id_pc, if_id_ir, exp_pc, word_at(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
        end
        stall = 1'b0; redirect = 1'b0;
        checks++; if (seen < 50) begin errors++; $display("FAIL rnd_progress: got %0d instructions exp >= 50", seen); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 + 32'(i);
        test_reset;
        test_stall;
        test_redirect;
        test_redirect_in_hold;
        test_reset_in_hold;
        test_wrap;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
